eac_accum: RTL and testbench
============================

# eac_accum

Sequential end-around-carry (ones' complement) accumulator: sums a stream of `len` words of width 2N, one word per clock under a valid/ready handshake, then folds the deferred carry and presents the ones' complement sum. It generalises the combinational two-operand EAC adder in the operational block to a configurable-length multi-word sum, with deferred carry for a short critical path. It sits between the register file/data bus and the result register.

## Interface
- `N`, 4: half data width; data words are 2N bits.
- `LEN_W`, 4: width of the word-count input.

- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a new sum; sampled only in IDLE.
- `len` input LEN_W: number of words to sum; sampled with `start`.
- `a` input 2N: data word.
- `in_valid` input 1: `a` is valid.
- `in_ready` output 1: block accepts a word this cycle.
- `sum_out` output 2N: registered result.
- `done` output 1: one-cycle pulse; `sum_out` is valid.
- `busy` output 1: high in any state other than IDLE.
- `ok` output 1: only with `EAC_CHECK_EN`; see Configuration.

## Operation
- Registers:
  - `acc` (2N bits), `carry` (1 bit), `cnt` (LEN_W bits), `sum_out`.
  - FSM states: IDLE, ACC, FOLD, DONE.
- IDLE:
  - `in_ready`=0.
  - If `start`=1 and `len`≠0: `acc`←0, `carry`←0, `cnt`←`len`, go to ACC.
  - If `start`=1 and `len`=0: `acc`←0, `carry`←0, go directly to FOLD.
- ACC:
  - `in_ready`=1.
  - A word is accepted on an edge where `in_valid`=1. On acceptance: `{carry, acc}` ← `acc` + `a` + `carry` (2N+1-bit result), and `cnt`←`cnt`−1.
  - When the word accepted has `cnt`=1, go to FOLD.
  - `in_valid`=0 stalls the block indefinitely; there is no timeout.
- FOLD:
  - Runs for one cycle with `in_ready`=0.
  - `acc` ← `acc` + `carry` (2N bits), then `carry`←0, go to DONE.
  - Invariant: `acc`=all-ones together with `carry`=1 is unreachable from reset, so this add never overflows.
- DONE:
  - Runs for one cycle.
  - `done`=1 and `sum_out`=`acc`. `sum_out` is loaded on the edge that enters DONE.
  - Go to IDLE.
- `sum_out` holds its value until the next DONE.
- `start` outside IDLE is ignored, including in the DONE cycle.
- Arithmetic is ones' complement:
  - Both all-zeros and all-ones are valid zeros.
  - The result is never normalised.

## Timing
- Reset values: state IDLE; `acc`=0; `carry`=0; `cnt`=0; `sum_out`=0; `done`=0; `busy`=0; `in_ready`=0; `ok`=0.
- Reset mid-operation: the sum is abandoned, no `done` is produced, and `sum_out` goes to 0.
- `start` edge → ACC in the next cycle, so the first word can be accepted one cycle after `start`.
- Throughput: one word per cycle while `in_valid` is held high.
- Latency: the edge that accepts the last word is t; FOLD occupies cycle t+1; `done` is high in cycle t+2.
  - Best-case total from the `start` edge: `len`+2 cycles.
  - For `len`=0: `done` is high 2 cycles after the `start` edge, with `sum_out`=0.
- `done` is high for exactly one cycle; `busy` falls in the cycle after `done`.

## Configuration
- Macro: `EAC_CHECK_EN`.
- Defined:
  - Port `ok` exists. It is registered and updated on entry to DONE, alongside `sum_out`.
  - `ok`=1 when the final `acc` is all-ones (checksum verify passes); otherwise `ok`=0.
  - `ok` holds its value until the next DONE.
- Undefined:
  - Port `ok` and its comparison logic are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use N=4 (8-bit words) unless stated otherwise.
- Carry fold: `len`=2, words 0xF0, 0x20 → after the last word `acc`=0x10 and `carry`=1; `done` in cycle t+2 with `sum_out`=0x11.
- Deferred carry chain: `len`=3, words 0xFF, 0xFF, 0x01 → `sum_out`=0x01; `done` pulses once, 5 cycles after the `start` edge.
- Handshake gaps: `len`=4, words 0x11, 0x22, 0x33, 0x44 with `in_valid` low for 2 cycles between each word → `sum_out`=0xAA; `in_ready` is high only in ACC.
- Boundaries:
  - `len`=0 → `done` 2 cycles after `start`, `sum_out`=0x00.
  - `start` pulsed mid-ACC → ignored; the result is unchanged.
- Reset mid-sum: `rst` asserted after 2 of 4 words → no `done`, all outputs 0; a following `len`=1 sum of 0x5A gives `sum_out`=0x5A.
- With `EAC_CHECK_EN`:
  - Words 0x0F, 0xF0 → `sum_out`=0xFF, `ok`=1.
  - Words 0x0F, 0xE0 → `sum_out`=0xEF, `ok`=0.

Source files
------------

// File: rtl/eac_accum_if.sv
// Handshake/data bundle for the end-around-carry accumulator.
// Optional EAC_CHECK_EN adds the checksum-verify flag `ok`.
interface eac_accum_if #(
  parameter int N     = 4,
  parameter int LEN_W = 4
);
  logic               start;
  logic [LEN_W-1:0]   len;
  logic [2*N-1:0]     a;
  logic               in_valid;
  logic               in_ready;
  logic [2*N-1:0]     sum_out;
  logic               done;
  logic               busy;
`ifdef EAC_CHECK_EN
  logic               ok;

  modport master (
    output start, len, a, in_valid,
    input  in_ready, sum_out, done, busy, ok
  );
  modport slave (
    input  start, len, a, in_valid,
    output in_ready, sum_out, done, busy, ok
  );
`else
  modport master (
    output start, len, a, in_valid,
    input  in_ready, sum_out, done, busy
  );
  modport slave (
    input  start, len, a, in_valid,
    output in_ready, sum_out, done, busy
  );
`endif
endinterface

// File: rtl/eac_accum.sv
// Multi-word ones' complement accumulator with deferred end-around carry.
// Define EAC_CHECK_EN to add the registered all-ones verify flag `ok`.
module eac_accum #(
  parameter int N     = 4,
  parameter int LEN_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  eac_accum_if.slave  bus
);
  localparam int W = 2 * N;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    FOLD,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_acc;
  logic             r_carry;
  logic [LEN_W-1:0] r_cnt;
  logic [W-1:0]     r_sum;
  logic             w_accept;
  logic             w_last;
  logic [W:0]       w_add;
  logic [W-1:0]     w_fold;

  assign w_accept = (r_state == ACC) && bus.in_valid;
  assign w_last   = (r_cnt == LEN_W'(1));

  // Carry out of each word is held back and fed into the next add
  assign w_add  = {1'b0, r_acc}
                + {1'b0, bus.a}
                + {{W{1'b0}}, r_carry};
  assign w_fold = r_acc + {{(W-1){1'b0}}, r_carry};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next = (bus.len != '0) ? ACC : FOLD;
        end
      end
      ACC: begin
        if (w_accept && w_last) begin
          w_next = FOLD;
        end
      end
      FOLD:    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && bus.start) begin
        r_acc   <= '0;
        r_carry <= 1'b0;
        r_cnt   <= bus.len;
      end
      if (w_accept) begin
        {r_carry, r_acc} <= w_add;
        r_cnt            <= r_cnt - LEN_W'(1);
      end
      if (r_state == FOLD) begin
        r_acc   <= w_fold;
        r_carry <= 1'b0;
        r_sum   <= w_fold;
      end
    end
  end

  assign bus.in_ready = (r_state == ACC);
  assign bus.done     = (r_state == DONE);
  assign bus.busy     = (r_state != IDLE);
  assign bus.sum_out  = r_sum;

`ifdef EAC_CHECK_EN
  logic r_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ok <= 1'b0;
    end else if (r_state == FOLD) begin
      r_ok <= (w_fold == {W{1'b1}});
    end
  end

  assign bus.ok = r_ok;
`endif

endmodule

// File: tb/tb_eac_accum.sv
// Bench for eac_accum: directed vector table, reset-abort sequence,
// and randomized sums against an integer fold-to-8-bit reference.
module tb_eac_accum;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  eac_accum_if #(.N(4), .LEN_W(4)) bus ();

  eac_accum #(.N(4), .LEN_W(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         n;
    logic [7:0] w0;
    logic [7:0] w1;
    logic [7:0] w2;
    logic [7:0] w3;
    logic [7:0] exp;
    int         gap;
    bit         poke;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] words [16];
  vec_t       tbl [8];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Ones' complement sum: plain integer total, then fold carries back in
  function automatic logic [7:0] ref_sum(input int n);
    int unsigned s;
    s = 0;
    for (int i = 0; i < n; i++) s += words[i];
    while (s > 255) s = (s & 255) + (s >> 8);
    return s[7:0];
  endfunction

  task automatic run_sum(input string nm, input int n, input int gap,
                         input bit poke, input logic [7:0] exp);
    int cyc;
    int idx;
    int g;
    int want;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.len      = 4'(n);
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    idx = 0;
    g   = 0;
    while (idx < n && cyc < 200) begin
      chk({nm, "/ready"}, 32'(bus.in_ready), 1);
      if (g == 0) begin
        bus.in_valid = 1'b1;
        bus.a        = words[idx];
        idx++;
        g = gap;
      end else begin
        bus.in_valid = 1'b0;
        bus.a        = 8'($urandom);
        g--;
      end
      bus.start = poke && (cyc == 2);
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    while (bus.done !== 1'b1 && cyc < 300) begin
      chk({nm, "/ready_lo"}, 32'(bus.in_ready), 0);
      @(negedge clk);
      cyc++;
    end
    want = n + ((n > 0) ? (n - 1) * gap : 0) + 2;
    chk({nm, "/done_cyc"}, 32'(cyc), 32'(want));
    chk({nm, "/sum"}, 32'(bus.sum_out), 32'(exp));
    chk({nm, "/busy_done"}, 32'(bus.busy), 1);
`ifdef EAC_CHECK_EN
    chk({nm, "/ok"}, 32'(bus.ok), 32'(exp == 8'hFF));
`endif
    if (poke) begin
      bus.start = 1'b1;
      bus.len   = 4'd1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk({nm, "/done_pulse"}, 32'(bus.done), 0);
    chk({nm, "/busy_idle"}, 32'(bus.busy), 0);
    chk({nm, "/sum_hold"}, 32'(bus.sum_out), 32'(exp));
  endtask

  initial begin
    int dn;
    int n;
    tbl[0] = '{2, 8'hF0, 8'h20, 8'h00, 8'h00, 8'h11, 0, 1'b0};
    tbl[1] = '{3, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h01, 0, 1'b0};
    tbl[2] = '{4, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 2, 1'b0};
    tbl[3] = '{0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0};
    tbl[4] = '{4, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 0, 1'b1};
    tbl[5] = '{2, 8'h0F, 8'hF0, 8'h00, 8'h00, 8'hFF, 0, 1'b0};
    tbl[6] = '{2, 8'h0F, 8'hE0, 8'h00, 8'h00, 8'hEF, 1, 1'b0};
    tbl[7] = '{1, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h5A, 0, 1'b0};

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.len      = '0;
    bus.a        = '0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst/sum", 32'(bus.sum_out), 0);
    chk("rst/done", 32'(bus.done), 0);
    chk("rst/busy", 32'(bus.busy), 0);
    chk("rst/ready", 32'(bus.in_ready), 0);
`ifdef EAC_CHECK_EN
    chk("rst/ok", 32'(bus.ok), 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      words[0] = tbl[i].w0;
      words[1] = tbl[i].w1;
      words[2] = tbl[i].w2;
      words[3] = tbl[i].w3;
      run_sum($sformatf("vec%0d", i), tbl[i].n, tbl[i].gap,
              tbl[i].poke, tbl[i].exp);
    end

    // Abort after two of four words
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = 4'd4;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = 8'h11;
    @(negedge clk);
    bus.a = 8'h22;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort/sum", 32'(bus.sum_out), 0);
    chk("abort/busy", 32'(bus.busy), 0);
    chk("abort/ready", 32'(bus.in_ready), 0);
    dn = 0;
    repeat (6) begin
      if (bus.done === 1'b1) dn++;
      @(negedge clk);
    end
    chk("abort/no_done", 32'(dn), 0);
    words[0] = 8'h5A;
    run_sum("after_abort", 1, 0, 1'b0, 8'h5A);

    for (int i = 0; i < 24; i++) begin
      n = $urandom_range(0, 10);
      for (int k = 0; k < 16; k++) begin
        if (i == 0)      words[k] = 8'h00;
        else if (i == 1) words[k] = 8'hFF;
        else             words[k] = 8'($urandom);
      end
      if (i < 2) n = 5;
      run_sum($sformatf("rnd%0d", i), n, $urandom_range(0, 2),
              1'(i % 5 == 3), ref_sum(n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
